pipelined_shifter: RTL and testbench

//  Registered, multi-mode barrel shifter for the datapath ALU: logical left/right,

---
 rtl/pipelined_shifter.sv | 154 +++++++++++++++
 tb/tb_pipelined_shifter.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_shifter.sv
// Registered multi-mode barrel shifter (LSL/LSR/ASR/ROL/ROR) with valid/ready handshake.
// Define SHIFTER_PIPE2_EN to split the shift over two registered stages (latency 2).
module pipelined_shifter #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [SHW-1:0]   sh,
    input  logic [2:0]       mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             lco,
    output logic             rco,
    output logic             zero,
    output logic             mode_err
);

    localparam logic [2:0] M_LSL = 3'b000;
    localparam logic [2:0] M_LSR = 3'b001;
    localparam logic [2:0] M_ASR = 3'b010;
    localparam logic [2:0] M_ROL = 3'b011;
    localparam logic [2:0] M_ROR = 3'b100;

    function automatic logic [WIDTH-1:0] shift_val(input logic [WIDTH-1:0] v,
                                                   input logic [SHW-1:0]   n,
                                                   input logic [2:0]       m);
        logic [2*WIDTH-1:0] d;
        d         = '0;
        shift_val = v;
        case (m)
            M_LSL: shift_val = v << n;
            M_LSR: shift_val = v >> n;
            M_ASR: shift_val = $signed(v) >>> n;
            M_ROL: begin
                d         = {v, v} << n;
                shift_val = d[2*WIDTH-1:WIDTH];
            end
            M_ROR: begin
                d         = {v, v} >> n;
                shift_val = d[WIDTH-1:0];
            end
            default: shift_val = v;
        endcase
    endfunction

    // Carries depend only on the operand and the full shift amount, so they are
    // resolved at accept time and ride with the beat.
    logic [SHW-1:0] lidx;
    logic [SHW-1:0] ridx;
    logic           lco_c;
    logic           rco_c;
    logic           err_c;

    always_comb begin
        lidx  = '0 - sh;
        ridx  = sh - SHW'(1);
        lco_c = 1'b0;
        rco_c = 1'b0;
        err_c = (mode > M_ROR);
        if (sh != '0) begin
            case (mode)
                M_LSL, M_ROL:        lco_c = a[lidx];
                M_LSR, M_ASR, M_ROR: rco_c = a[ridx];
                default: ;
            endcase
        end
    end

    assign zero = (result == '0);

`ifdef SHIFTER_PIPE2_EN
    localparam int             LO     = SHW / 2;
    localparam logic [SHW-1:0] LOMASK = SHW'((1 << LO) - 1);

    logic             s1_valid;
    logic [WIDTH-1:0] s1_data;
    logic [SHW-1:0]   s1_n2;
    logic [2:0]       s1_mode;
    logic             s1_lco;
    logic             s1_rco;
    logic             s1_err;
    logic             s2_adv;

    assign s2_adv   = !out_valid | out_ready;
    assign in_ready = !s1_valid | s2_adv;

    // Stage 1 applies the upper shift bits; the lower bits are kept for stage 2.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_data  <= '0;
            s1_n2    <= '0;
            s1_mode  <= '0;
            s1_lco   <= 1'b0;
            s1_rco   <= 1'b0;
            s1_err   <= 1'b0;
        end else if (in_ready) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_data <= shift_val(a, sh & ~LOMASK, mode);
                s1_n2   <= sh & LOMASK;
                s1_mode <= mode;
                s1_lco  <= lco_c;
                s1_rco  <= rco_c;
                s1_err  <= err_c;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            result    <= '0;
            lco       <= 1'b0;
            rco       <= 1'b0;
            mode_err  <= 1'b0;
        end else if (s2_adv) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                result   <= shift_val(s1_data, s1_n2, s1_mode);
                lco      <= s1_lco;
                rco      <= s1_rco;
                mode_err <= s1_err;
            end
        end
    end
`else
    assign in_ready = !out_valid | out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            result    <= '0;
            lco       <= 1'b0;
            rco       <= 1'b0;
            mode_err  <= 1'b0;
        end else if (in_valid && in_ready) begin
            out_valid <= 1'b1;
            result    <= shift_val(a, sh, mode);
            lco       <= lco_c;
            rco       <= rco_c;
            mode_err  <= err_c;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_pipelined_shifter.sv
// Scoreboard bench for pipelined_shifter (WIDTH=32); expected values come from a
// bit-serial reference model. Latency expectation follows SHIFTER_PIPE2_EN.
module tb_pipelined_shifter;

`ifdef SHIFTER_PIPE2_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    typedef struct packed {
        logic [31:0] res;
        logic        lco;
        logic        rco;
        logic        err;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [4:0]  sh;
    logic [2:0]  mode;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        lco;
    logic        rco;
    logic        zero;
    logic        mode_err;

    int   n_checks = 0;
    int   n_errors = 0;
    int   n_pops   = 0;
    exp_t sbq[$];

    pipelined_shifter #(.WIDTH(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .sh        (sh),
        .mode      (mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .lco       (lco),
        .rco       (rco),
        .zero      (zero),
        .mode_err  (mode_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    // One bit position per step, tracking the last bit shifted out.
    function automatic exp_t model(input logic [31:0] va, input logic [4:0] n, input logic [2:0] m);
        exp_t e;
        e.res = va;
        e.lco = 1'b0;
        e.rco = 1'b0;
        e.err = (m > 3'd4);
        if (!e.err) begin
            for (int unsigned i = 0; i < n; i++) begin
                case (m)
                    3'd0: begin e.lco = e.res[31]; e.res = {e.res[30:0], 1'b0}; end
                    3'd1: begin e.rco = e.res[0];  e.res = {1'b0, e.res[31:1]}; end
                    3'd2: begin e.rco = e.res[0];  e.res = {e.res[31], e.res[31:1]}; end
                    3'd3: begin e.lco = e.res[31]; e.res = {e.res[30:0], e.res[31]}; end
                    default: begin e.rco = e.res[0]; e.res = {e.res[0], e.res[31:1]}; end
                endcase
            end
        end
        return e;
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            sbq.delete();
        end else begin
            if (out_valid && out_ready) begin
                if (sbq.size() == 0) begin
                    check("sb_underflow", 64'(sbq.size()), 64'd1);
                end else begin
                    e = sbq.pop_front();
                    n_pops++;
                    check("sb_result", result, e.res);
                    check("sb_lco", lco, e.lco);
                    check("sb_rco", rco, e.rco);
                    check("sb_mode_err", mode_err, e.err);
                    check("sb_zero", zero, e.res == 32'd0);
                end
            end
            if (in_valid && in_ready)
                sbq.push_back(model(a, sh, mode));
        end
    end

    // Called at posedge+#1; returns at posedge+#1 after the accepting edge.
    task automatic send(input logic [31:0] ta, input logic [4:0] tsh, input logic [2:0] tm);
        int   waitc;
        logic go;
        waitc    = 0;
        go       = 1'b0;
        in_valid = 1'b1;
        a        = ta;
        sh       = tsh;
        mode     = tm;
        forever begin
            @(negedge clk);
            go = in_ready;
            @(posedge clk);
            #1;
            if (go) break;
            waitc++;
            if (waitc > 100) begin
                check("send_timeout", {63'd0, go}, 64'd1);
                break;
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic directed(input string tag, input logic [31:0] ta, input logic [4:0] tsh,
                            input logic [2:0] tm, input logic [31:0] xr, input logic xl,
                            input logic xrc, input logic xe);
        int lat;
        out_ready = 1'b1;
        send(ta, tsh, tm);
        lat = 1;
        while (!out_valid && lat < 8) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check({tag, "_lat"}, 64'(lat), 64'(LAT));
        check({tag, "_res"}, result, xr);
        check({tag, "_lco"}, lco, xl);
        check({tag, "_rco"}, rco, xrc);
        check({tag, "_err"}, mode_err, xe);
        check({tag, "_zero"}, zero, xr == 32'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic reset_check(input string tag);
        rst_n    = 1'b0;
        in_valid = 1'b1;
        a        = $urandom;
        sh       = 5'($urandom);
        mode     = 3'd0;
        repeat (2) begin
            @(negedge clk);
            check({tag, "_ov"}, out_valid, 1'b0);
            check({tag, "_res"}, result, 32'd0);
            check({tag, "_zero"}, zero, 1'b1);
        end
        @(posedge clk);
        #1;
        rst_n    = 1'b1;
        in_valid = 1'b0;
        repeat (2) begin
            @(negedge clk);
            check({tag, "_post_ov"}, out_valid, 1'b0);
            check({tag, "_post_zero"}, zero, 1'b1);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input string tag);
        int w;
        w = 0;
        out_ready = 1'b1;
        while ((sbq.size() != 0 || out_valid) && w < 200) begin
            @(posedge clk);
            #1;
            w++;
        end
        check(tag, 64'(sbq.size()), 64'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e1;
        int   held;
        int   p0;
        bit   done;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        a         = '0;
        sh        = '0;
        mode      = '0;
        #1;
        reset_check("rst");

        directed("lsl1", 32'h8000_0001, 5'd1, 3'b000, 32'h0000_0002, 1'b1, 1'b0, 1'b0);
        directed("asr1", 32'h8000_0003, 5'd1, 3'b010, 32'hC000_0001, 1'b0, 1'b1, 1'b0);
        directed("ror1", 32'h8000_0003, 5'd1, 3'b100, 32'hC000_0001, 1'b0, 1'b1, 1'b0);
        directed("lsr1", 32'h8000_0003, 5'd1, 3'b001, 32'h4000_0001, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++)
            directed($sformatf("sh0_m%0d", i), 32'hDEAD_BEEF, 5'd0, 3'(i), 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b0);
        directed("rol31", 32'h0000_0001, 5'd31, 3'b011, 32'h8000_0000, 1'b0, 1'b0, 1'b0);
        directed("ill110", 32'h0000_1234, 5'd3, 3'b110, 32'h0000_1234, 1'b0, 1'b0, 1'b1);
        directed("legal_after", 32'h0000_1234, 5'd4, 3'b000, 32'h0001_2340, 1'b0, 1'b0, 1'b0);
        directed("zero_lsr", 32'h0000_0001, 5'd1, 3'b001, 32'h0000_0000, 1'b0, 1'b1, 1'b0);
        directed("ror31", 32'h0000_0001, 5'd31, 3'b100, 32'h0000_0002, 1'b0, 1'b0, 1'b0);

        // Backpressure: three beats against a stalled consumer.
        p0   = n_pops;
        e1   = model(32'h0000_00F0, 5'd4, 3'b000);
        held = 0;
        fork
            begin
                send(32'h0000_00F0, 5'd4, 3'b000);
                send(32'hF000_0000, 5'd4, 3'b010);
                send(32'h0000_0001, 5'd1, 3'b100);
            end
            begin
                out_ready = 1'b0;
                repeat (4) begin
                    @(negedge clk);
                    if (out_valid) begin
                        check("bp_hold", result, e1.res);
                        held++;
                    end
                end
                check("bp_held_cycles", 64'(held), 64'(4 - LAT));
                check("bp_in_ready", in_ready, 1'b0);
                @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        drain("bp_drain");
        check("bp_count", 64'(n_pops - p0), 64'd3);

        // Random traffic with random consumer stalls.
        p0   = n_pops;
        done = 1'b0;
        fork
            begin
                for (int i = 0; i < 300; i++)
                    send($urandom, 5'($urandom), 3'($urandom_range(0, 7)));
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge clk);
                    #1;
                    out_ready = ($urandom_range(0, 3) != 0);
                end
            end
        join
        drain("rand_drain");
        check("rand_count", 64'(n_pops - p0), 64'd300);

        // Reset with a beat in flight: it must vanish.
        out_ready = 1'b0;
        send(32'hFFFF_0000, 5'd8, 3'b001);
        reset_check("midrst");
        check("midrst_q", 64'(sbq.size()), 64'd0);
        out_ready = 1'b1;
        directed("post_rst", 32'h0F00_0000, 5'd4, 3'b011, 32'hF000_0000, 1'b0, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
